// File: rtl/chacha_ksg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// chacha_ksg_ctrl_pkg
// Shared definitions for the ChaCha keystream-generator sequencing controller:
//   - controller state encoding
//   - field widths of the small-scale ChaCha configuration and data word
//   - keystream word packing order (final_out1 occupies the top nibble)
// ---------------------------------------------------------------------------
package chacha_ksg_ctrl_pkg;

  localparam int unsigned CONST_W   = 4;
  localparam int unsigned KEY_W     = 8;
  localparam int unsigned CTR_W     = 2;
  localparam int unsigned NONCE_W   = 2;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned KS_LANE_W = 4;
  localparam int unsigned KS_LANES  = WORD_W / KS_LANE_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    GEN       = 3'd2,
    OUT       = 3'd3,
    EXHAUSTED = 3'd4
  } state_t;

  // Packs the four ksg lanes into one keystream word; lane 1 lands in 15:12.
  function automatic logic [WORD_W-1:0] ks_pack(
    input logic [KS_LANE_W-1:0] out1,
    input logic [KS_LANE_W-1:0] out2,
    input logic [KS_LANE_W-1:0] out3,
    input logic [KS_LANE_W-1:0] out4
  );
    return {out1, out2, out3, out4};
  endfunction

  // Extracts ksg lane 1..4 from a packed keystream word.
  function automatic logic [KS_LANE_W-1:0] ks_lane(
    input logic [WORD_W-1:0] ks,
    input int unsigned       lane
  );
    logic [KS_LANE_W-1:0] lane_s;
    case (lane)
      1:       lane_s = ks[15:12];
      2:       lane_s = ks[11:8];
      3:       lane_s = ks[7:4];
      4:       lane_s = ks[3:0];
      default: lane_s = {KS_LANE_W{1'b0}};
    endcase
    return lane_s;
  endfunction

endpackage

// File: rtl/chacha_ksg_ctrl_if.sv
// ---------------------------------------------------------------------------
// chacha_ksg_ctrl_if
// Host-side streams of the ChaCha controller:
//   cfg  : cfg_valid/cfg_ready handshake carrying constant, key, nonce
//   in   : plaintext word stream in_valid/in_ready/in_data
//   out  : ciphertext stream out_valid/out_ready/out_data plus out_ctr
// Modports:
//   master : host side (offers config and plaintext, sinks ciphertext)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface chacha_ksg_ctrl_if;
  import chacha_ksg_ctrl_pkg::*;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CONST_W-1:0] cfg_constant;
  logic [KEY_W-1:0]   cfg_key;
  logic [NONCE_W-1:0] cfg_nonce;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;

  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  out_data;
  logic [CTR_W-1:0]   out_ctr;

  modport master (
    output cfg_valid, cfg_constant, cfg_key, cfg_nonce,
    output in_valid, in_data,
    output out_ready,
    input  cfg_ready, in_ready,
    input  out_valid, out_data, out_ctr
  );

  modport slave (
    input  cfg_valid, cfg_constant, cfg_key, cfg_nonce,
    input  in_valid, in_data,
    input  out_ready,
    output cfg_ready, in_ready,
    output out_valid, out_data, out_ctr
  );

endinterface

// File: rtl/chacha_ksg_ctrl_cfg_regs.sv
// ---------------------------------------------------------------------------
// chacha_ksg_ctrl_cfg_regs
// Configuration register bank for the ChaCha controller.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en             : configuration handshake strobe
//   wr_constant/key/nonce : configuration offered by the host
//   cfg_constant_r/cfg_key_r/cfg_nonce_r : latched configuration (to ksg)
//   keyed_r           : set once any configuration has been latched
// ---------------------------------------------------------------------------
module chacha_ksg_ctrl_cfg_regs
  import chacha_ksg_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CONST_W-1:0] wr_constant,
  input  logic [KEY_W-1:0]   wr_key,
  input  logic [NONCE_W-1:0] wr_nonce,
  output logic [CONST_W-1:0] cfg_constant_r,
  output logic [KEY_W-1:0]   cfg_key_r,
  output logic [NONCE_W-1:0] cfg_nonce_r,
  output logic               keyed_r
);

  // Latch the configuration on each accepted handshake; keyed stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_constant_r <= {CONST_W{1'b0}};
      cfg_key_r      <= {KEY_W{1'b0}};
      cfg_nonce_r    <= {NONCE_W{1'b0}};
      keyed_r        <= 1'b0;
    end else if (wr_en) begin
      cfg_constant_r <= wr_constant;
      cfg_key_r      <= wr_key;
      cfg_nonce_r    <= wr_nonce;
      keyed_r        <= 1'b1;
    end else begin
      cfg_constant_r <= cfg_constant_r;
      cfg_key_r      <= cfg_key_r;
      cfg_nonce_r    <= cfg_nonce_r;
      keyed_r        <= keyed_r;
    end
  end

endmodule

// File: rtl/chacha_ksg_ctrl.sv
// ---------------------------------------------------------------------------
// chacha_ksg_ctrl
// Sequencing controller for the combinational ChaCha keystream generator.
// Holds key/constant/nonce, drives the block counter into ksg, XORs each
// accepted plaintext word with the sampled keystream and emits ciphertext.
// Only MAX_BLOCKS words are allowed per configuration (counter exhaustion).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : cfg / plaintext / ciphertext streams
//   ksg_constant, ksg_key, ksg_counter, ksg_nonce : inputs of the ksg
//   ksg_ks        : packed keystream from ksg (lane 1 in bits 15:12)
//   keyed         : a configuration is loaded
//   exhausted     : all block counters of this configuration consumed
// Parameters:
//   KS_WAIT    : cycles ksg inputs are held stable before sampling (1..7)
//   MAX_BLOCKS : blocks per configuration (2**CTR_W)
// Build option:
//   CHACHA_CTR_WRAP_EN : counter wraps to 0 after the last block instead of
//                        exhausting; exhausted stays 0 (characterisation only)
// ---------------------------------------------------------------------------
module chacha_ksg_ctrl
  import chacha_ksg_ctrl_pkg::*;
#(
  parameter int unsigned KS_WAIT    = 1,
  parameter int unsigned MAX_BLOCKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  chacha_ksg_ctrl_if.slave   bus,
  output logic [CONST_W-1:0] ksg_constant,
  output logic [KEY_W-1:0]   ksg_key,
  output logic [CTR_W-1:0]   ksg_counter,
  output logic [NONCE_W-1:0] ksg_nonce,
  input  logic [WORD_W-1:0]  ksg_ks,
  output logic               keyed,
  output logic               exhausted
);

  localparam int unsigned          WAIT_W    = 3;
  localparam logic [WAIT_W-1:0]    WAIT_LOAD = WAIT_W'(KS_WAIT);
  localparam logic [WAIT_W-1:0]    WAIT_ONE  = 3'd1;
  localparam logic [CTR_W-1:0]     CTR_LAST  = CTR_W'(MAX_BLOCKS - 1);
  localparam logic [CTR_W-1:0]     CTR_ONE   = 2'd1;

  state_t             state_r;
  logic [CTR_W-1:0]   ctr_r;
  logic [WORD_W-1:0]  in_reg_r;
  logic [WORD_W-1:0]  out_data_r;
  logic [CTR_W-1:0]   out_ctr_r;
  logic               out_valid_r;
  logic               exhausted_r;
  logic [WAIT_W-1:0]  wait_r;

  logic               cfg_ready_s;
  logic               in_ready_s;
  logic               cfg_hs_s;
  logic               in_hs_s;

  logic [CONST_W-1:0] cfg_constant_r;
  logic [KEY_W-1:0]   cfg_key_r;
  logic [NONCE_W-1:0] cfg_nonce_r;
  logic               keyed_r;

  chacha_ksg_ctrl_cfg_regs u_cfg_regs (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (cfg_hs_s),
    .wr_constant    (bus.cfg_constant),
    .wr_key         (bus.cfg_key),
    .wr_nonce       (bus.cfg_nonce),
    .cfg_constant_r (cfg_constant_r),
    .cfg_key_r      (cfg_key_r),
    .cfg_nonce_r    (cfg_nonce_r),
    .keyed_r        (keyed_r)
  );

  // Handshake readiness; a config offered in READY blocks plaintext that cycle.
  always_comb begin
    cfg_ready_s = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE:      cfg_ready_s = 1'b1;
      READY: begin
        cfg_ready_s = 1'b1;
        in_ready_s  = ~bus.cfg_valid;
      end
      EXHAUSTED: cfg_ready_s = 1'b1;
      GEN:       cfg_ready_s = 1'b0;
      OUT:       cfg_ready_s = 1'b0;
      default: begin
        cfg_ready_s = 1'b0;
        in_ready_s  = 1'b0;
      end
    endcase
  end

  assign cfg_hs_s = bus.cfg_valid & cfg_ready_s;
  assign in_hs_s  = bus.in_valid & in_ready_s;

  // Controller FSM with its registered outputs.
  // GEN samples the keystream on the edge after the wait counter has run out,
  // so out_valid rises KS_WAIT+1 edges after the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ctr_r       <= {CTR_W{1'b0}};
      in_reg_r    <= {WORD_W{1'b0}};
      out_data_r  <= {WORD_W{1'b0}};
      out_ctr_r   <= {CTR_W{1'b0}};
      out_valid_r <= 1'b0;
      exhausted_r <= 1'b0;
      wait_r      <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_hs_s) begin
            ctr_r       <= {CTR_W{1'b0}};
            exhausted_r <= 1'b0;
            state_r     <= READY;
          end
        end
        READY: begin
          if (cfg_hs_s) begin
            ctr_r       <= {CTR_W{1'b0}};
            exhausted_r <= 1'b0;
            state_r     <= READY;
          end else if (in_hs_s) begin
            in_reg_r <= bus.in_data;
            wait_r   <= WAIT_LOAD;
            state_r  <= GEN;
          end
        end
        GEN: begin
          if (wait_r == {WAIT_W{1'b0}}) begin
            out_data_r  <= in_reg_r ^ ksg_ks;
            out_ctr_r   <= ctr_r;
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end else begin
            wait_r <= wait_r - WAIT_ONE;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (ctr_r == CTR_LAST) begin
`ifdef CHACHA_CTR_WRAP_EN
              ctr_r   <= {CTR_W{1'b0}};
              state_r <= READY;
`else
              // Counter held at the last block; only a new config recovers.
              exhausted_r <= 1'b1;
              state_r     <= EXHAUSTED;
`endif
            end else begin
              ctr_r   <= ctr_r + CTR_ONE;
              state_r <= READY;
            end
          end
        end
        EXHAUSTED: begin
          if (cfg_hs_s) begin
            ctr_r       <= {CTR_W{1'b0}};
            exhausted_r <= 1'b0;
            state_r     <= READY;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ctr   = out_ctr_r;

  assign ksg_constant = cfg_constant_r;
  assign ksg_key      = cfg_key_r;
  assign ksg_counter  = ctr_r;
  assign ksg_nonce    = cfg_nonce_r;

  assign keyed     = keyed_r;
  assign exhausted = exhausted_r;

endmodule
